// File: rtl/synapse_pkg.sv
// Shared constants and width helpers for the synapse scheduler / MAC accumulator pair.
package synapse_pkg;

    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_SUB  = 2'b10;
    localparam logic [1:0] SEL_SKIP = 2'b00;

    localparam int CTRL_FIRST = 1;
    localparam int CTRL_LAST  = 0;

    function automatic int sel_width(input bit is_rc);
        return is_rc ? 2 : 1;
    endfunction

    function automatic int token_width(input int sw, input int na);
        return 2 + sw + $clog2(na);
    endfunction

endpackage

// File: rtl/synapse_weight_ram.sv
// NA x WW weight store: one write port, one synchronous read port, old data on collision.
module synapse_weight_ram #(
    parameter int NA  = 4,
    parameter int WW  = 8,
    parameter int AAW = $clog2(NA)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AAW-1:0] waddr,
    input  logic [WW-1:0]  wdata,
    input  logic [AAW-1:0] raddr,
    output logic [WW-1:0]  rdata
);

    logic [WW-1:0] mem [NA];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/synapse_maccum.sv
// Differential multiply-accumulate stage: fetches one weight per token, adds/subtracts/skips it,
// and emits the finished sum through a valid/ready register slice.
module synapse_maccum
    import synapse_pkg::*;
#(
    parameter int    NA   = 4,
    parameter string TYPE = "rc",
    parameter int    WW   = 8,
    parameter int    AW   = WW + $clog2(NA) + 1,
    localparam int   AAW  = $clog2(NA),
    localparam int   SW   = sel_width(TYPE == "rc"),
    localparam int   TW   = token_width(SW, NA)
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic           iValid_AM,
    output logic           oReady_AM,
    input  logic [TW-1:0]  iData_AM,
    input  logic           iWe,
    input  logic [AAW-1:0] iWAddr,
    input  logic [WW-1:0]  iWData,
    output logic           oValid_BM,
    input  logic           iReady_BM,
    output logic [AW-1:0]  oData_BM
);

    logic [1:0]     tok_ctrl;
    logic [SW-1:0]  tok_sel;
    logic [AAW-1:0] tok_addr;

    assign {tok_ctrl, tok_sel, tok_addr} = iData_AM;

    logic           s1_valid;
    logic           s1_first;
    logic           s1_last;
    logic [SW-1:0]  s1_sel;
    logic [AAW-1:0] s1_addr;

    logic           out_valid;
    logic [AW-1:0]  out_data;

    logic           stall;
    logic           accept;
    logic           fire;
    logic [AAW-1:0] raddr;
    logic [WW-1:0]  rdata;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] wext;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] base;
    logic signed [AW-1:0] acc_next;

    // Only a finished sum that cannot drain blocks the pipe; partial sums keep flowing.
    assign stall     = s1_valid && s1_last && out_valid && !iReady_BM;
    assign oReady_AM = !stall;
    assign accept    = iValid_AM && !stall;
    assign fire      = s1_valid && !stall;
    // Re-reading the held address keeps the RAM output aligned with S1 through a stall.
    assign raddr     = stall ? s1_addr : tok_addr;

    synapse_weight_ram #(
        .NA (NA),
        .WW (WW),
        .AAW(AAW)
    ) u_ram (
        .clk  (iCLK),
        .we   (iWe),
        .waddr(iWAddr),
        .wdata(iWData),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign wext = {{(AW - WW){rdata[WW-1]}}, rdata};

    generate
        if (SW == 2) begin : g_rc
            always_comb begin
                term = '0;
                case (s1_sel)
                    SEL_ADD: term = wext;
                    SEL_SUB: term = -wext;
                    default: term = '0;
                endcase
            end
        end else begin : g_sc
            always_comb begin
                term = '0;
                if (s1_sel[0]) begin
                    term = wext;
                end
            end
        end
    endgenerate

    assign base     = s1_first ? '0 : acc;
    assign acc_next = base + term;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sel    <= '0;
            s1_addr   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (!stall) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_first <= tok_ctrl[CTRL_FIRST];
                    s1_last  <= tok_ctrl[CTRL_LAST];
                    s1_sel   <= tok_sel;
                    s1_addr  <= tok_addr;
                end
            end

            if (fire) begin
                acc <= s1_last ? '0 : acc_next;
            end

            if (out_valid && iReady_BM) begin
                out_valid <= 1'b0;
            end
            if (fire && s1_last) begin
                out_valid <= 1'b1;
                out_data  <= acc_next;
            end
        end
    end

    assign oValid_BM = out_valid;
    assign oData_BM  = out_data;

endmodule

// File: tb/tb_synapse_maccum.sv
// Self-checking bench for synapse_maccum: directed vectors, corner sequences and a random soak.
module tb_synapse_maccum;

    localparam int NA    = 4;
    localparam int WW    = 8;
    localparam int AW    = 11;
    localparam int AAW   = 2;
    localparam int TW    = 6;
    localparam int TW_SC = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [TW-1:0]  in_data;
    logic           we;
    logic [AAW-1:0] waddr;
    logic [WW-1:0]  wdata;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_data;

    logic             sc_in_valid;
    logic             sc_in_ready;
    logic [TW_SC-1:0] sc_in_data;
    logic             sc_out_valid;
    logic [AW-1:0]    sc_out_data;

    synapse_maccum #(
        .NA  (NA),
        .TYPE("rc"),
        .WW  (WW),
        .AW  (AW)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iValid_AM(in_valid),
        .oReady_AM(in_ready),
        .iData_AM (in_data),
        .iWe      (we),
        .iWAddr   (waddr),
        .iWData   (wdata),
        .oValid_BM(out_valid),
        .iReady_BM(out_ready),
        .oData_BM (out_data)
    );

    // The single-bit-select variant shares the weight write port, so its RAM mirrors dut's.
    synapse_maccum #(
        .NA  (NA),
        .TYPE("sc"),
        .WW  (WW),
        .AW  (AW)
    ) dut_sc (
        .iCLK     (clk),
        .iRST     (rst),
        .iValid_AM(sc_in_valid),
        .oReady_AM(sc_in_ready),
        .iData_AM (sc_in_data),
        .iWe      (we),
        .iWAddr   (waddr),
        .iWData   (wdata),
        .oValid_BM(sc_out_valid),
        .iReady_BM(1'b1),
        .oData_BM (sc_out_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int w_model [NA];
    int q_exp [$];
    int run_sum = 0;

    int  last_acc_cyc = 0;
    int  rise_cyc     = -1;
    bit  ready_low    = 1'b0;
    bit  prev_valid   = 1'b0;
    bit  prev_hold    = 1'b0;
    int  prev_data    = 0;
    bit  soak_done    = 1'b0;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] addr;
        int         exp;
    } vec_t;

    vec_t tbl [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int term_of(input logic [1:0] sel, input logic [1:0] a);
        case (sel)
            2'b01:   return w_model[a];
            2'b10:   return -w_model[a];
            default: return 0;
        endcase
    endfunction

    // Output monitor: sampled at negedge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), prev_data);
            end
            if (out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
            if (!in_ready) ready_low = 1'b1;
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sum_unexpected: got %0d, expected no output",
                             int'($signed(out_data)));
                end else begin
                    chk("sum", int'($signed(out_data)), q_exp.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = int'(out_data);
        end
        prev_valid = out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit first, input bit last, input logic [1:0] sel,
                        input logic [1:0] addr);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1;
        in_data  = {first, last, sel, addr};
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) last_acc_cyc = cyc;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept, expected accept within 1000 cycles");
        end
    endtask

    task automatic send_m(input bit first, input bit last, input logic [1:0] sel,
                          input logic [1:0] addr);
        if (first) run_sum = 0;
        run_sum += term_of(sel, addr);
        if (last) begin
            q_exp.push_back(run_sum);
            run_sum = 0;
        end
        send(first, last, sel, addr);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d sums pending, expected 0", q_exp.size());
            q_exp.delete();
        end
        step();
        step();
    endtask

    task automatic wr_weight(input int a, input int val);
        assert (!in_valid && !sc_in_valid);
        we    = 1'b1;
        waddr = AAW'(a);
        wdata = WW'(val);
        step();
        we = 1'b0;
        w_model[a] = val;
    endtask

    task automatic load_weights(input int w0, input int w1, input int w2, input int w3);
        repeat (3) step();
        wr_weight(0, w0);
        wr_weight(1, w1);
        wr_weight(2, w2);
        wr_weight(3, w3);
        step();
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        out_ready   = 1'b1;
        sc_in_valid = 1'b0;
        sc_in_data  = '0;

        tbl[0] = '{2'b01, 2'd0, 5};
        tbl[1] = '{2'b10, 2'd1, 3};
        tbl[2] = '{2'b00, 2'd2, 0};
        tbl[3] = '{2'b11, 2'd3, 0};
        tbl[4] = '{2'b10, 2'd3, -100};
        tbl[5] = '{2'b01, 2'd1, -3};
        tbl[6] = '{2'b10, 2'd0, -5};
        tbl[7] = '{2'b01, 2'd3, 100};

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_ready", int'(in_ready), 1);
        step();

        load_weights(5, -3, 7, 100);

        // Single-bit select variant: +a0, skip a1, +a2, skip a3 (last).
        sc_in_valid = 1'b1;
        sc_in_data = {1'b1, 1'b0, 1'b1, 2'd0}; step();
        sc_in_data = {1'b0, 1'b0, 1'b0, 2'd1}; step();
        sc_in_data = {1'b0, 1'b0, 1'b1, 2'd2}; step();
        sc_in_data = {1'b0, 1'b1, 1'b0, 2'd3}; step();
        sc_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!sc_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("sc_valid", int'(sc_out_valid), 1);
        chk("sc_sum", int'($signed(sc_out_data)), 12);
        step();

        // Single-token sums from the vector table.
        for (int i = 0; i < 8; i++) begin
            q_exp.push_back(tbl[i].exp);
            send(1'b1, 1'b1, tbl[i].sel, tbl[i].addr);
        end
        wait_drain(50);

        // Back-to-back four-token sequence, no backpressure.
        ready_low = 1'b0;
        rise_cyc  = -1;
        q_exp.push_back(108);
        send(1'b1, 1'b0, 2'b01, 2'd0);
        send(1'b0, 1'b0, 2'b10, 2'd1);
        send(1'b0, 1'b0, 2'b00, 2'd2);
        send(1'b0, 1'b1, 2'b01, 2'd3);
        wait_drain(50);
        chk("latency", rise_cyc - last_acc_cyc, 2);
        chk("ready_never_low", int'(ready_low), 0);

        // Two sums queued behind a stalled consumer.
        out_ready = 1'b0;
        q_exp.push_back(108);
        q_exp.push_back(3);
        send(1'b1, 1'b0, 2'b01, 2'd0);
        send(1'b0, 1'b0, 2'b10, 2'd1);
        send(1'b0, 1'b0, 2'b00, 2'd2);
        send(1'b0, 1'b1, 2'b01, 2'd3);
        send(1'b1, 1'b1, 2'b10, 2'd1);
        @(negedge clk);
        chk("stall_ready", int'(in_ready), 0);
        chk("stall_valid", int'(out_valid), 1);
        repeat (3) step();
        @(negedge clk);
        chk("stall_ready_held", int'(in_ready), 0);
        step();
        out_ready = 1'b1;
        wait_drain(50);

        // Most negative weights at every address.
        load_weights(-128, -128, -128, -128);
        q_exp.push_back(-512);
        send(1'b1, 1'b0, 2'b01, 2'd0);
        send(1'b0, 1'b0, 2'b01, 2'd1);
        send(1'b0, 1'b0, 2'b01, 2'd2);
        send(1'b0, 1'b1, 2'b01, 2'd3);
        wait_drain(50);

        // Reset in the middle of a sequence, then a sequence without a first token.
        load_weights(5, -3, 7, 100);
        send(1'b1, 1'b0, 2'b01, 2'd0);
        send(1'b0, 1'b0, 2'b01, 2'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_sum = 0;
        @(negedge clk);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_ready", int'(in_ready), 1);
        step();
        q_exp.push_back(105);
        send(1'b0, 1'b0, 2'b01, 2'd0);
        send(1'b0, 1'b1, 2'b01, 2'd3);
        wait_drain(50);

        // Random soak with random backpressure against the reference model.
        load_weights($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                     $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        run_sum   = 0;
        soak_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    send_m($urandom_range(0, 3) == 0,
                           ($urandom_range(0, 3) == 0) || (i == 9999),
                           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 4) == 0) step();
                end
                soak_done = 1'b1;
            end
            begin
                while (!soak_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
